challenge_prober: RTL and testbench

//  Digital stimulus/measure stage wrapped around the analog challenge cell.

---
 rtl/challenge_prober.sv | 101 ++++++++++
 tb/tb_challenge_prober.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/challenge_prober.sv
// Stimulus/measure stage for the analog challenge cell: launches a controlled edge
// on chal_in and counts clk cycles until the synchronised chal_out follows it.
module challenge_prober #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1000,
  parameter int SYNC_STAGES = 2,
  parameter bit INVERT      = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             polarity,
  input  logic             chal_out,
  output logic             chal_in,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] delay
);

  // state   | meaning
  // IDLE    | waiting for start; chal_in holds its last level
  // PRESET  | chal_in at pre-edge level, waiting for the cell to settle
  // MEASURE | edge launched, counting cycles until the cell follows
  typedef enum logic [1:0] {IDLE, PRESET, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_TO   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   matched;

  // The cell output is compared against the level it should settle to
  assign matched = (sync[SYNC_STAGES-1] == (chal_in ^ INVERT));
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], chal_out};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      chal_in <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      delay   <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= PRESET;
            chal_in <= polarity;
            cnt     <= '0;
            timeout <= 1'b0;
            delay   <= '0;
          end
        end
        PRESET: begin
          if (matched) begin
            state   <= MEASURE;
            chal_in <= ~chal_in;
            cnt     <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= IDLE;
            timeout <= 1'b1;
            delay   <= '0;
            done    <= 1'b1;
          end else begin
            cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
          end
        end
        MEASURE: begin
          if (matched) begin
            state <= IDLE;
            delay <= cnt;
            done  <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state   <= IDLE;
            timeout <= 1'b1;
            delay   <= CNT_TO;
            done    <= 1'b1;
          end else begin
            cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_challenge_prober.sv
// Directed bench for challenge_prober: wire, delayed, stuck and inverting cell models.
module tb_challenge_prober;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, polarity, chal_out, chal_in, busy, done, timeout;
  logic [15:0] delay;
  logic        start_inv, chal_in_inv, busy_inv, done_inv, timeout_inv;
  logic [15:0] delay_inv;
  logic [4:0]  line;
  int          mode;  // 0 wire, 1 five-cycle delay, 2 stuck 0, 3 stuck 1
  int          tests  = 0;
  int          failed = 0;
  int          done_cnt, busy_cnt;

  always #5 clk = ~clk;

  challenge_prober u_dut (
    .clk(clk), .rst(rst), .start(start), .polarity(polarity), .chal_out(chal_out),
    .chal_in(chal_in), .busy(busy), .done(done), .timeout(timeout), .delay(delay)
  );

  challenge_prober #(.INVERT(1'b1)) u_inv (
    .clk(clk), .rst(rst), .start(start_inv), .polarity(1'b0), .chal_out(~chal_in_inv),
    .chal_in(chal_in_inv), .busy(busy_inv), .done(done_inv), .timeout(timeout_inv),
    .delay(delay_inv)
  );

  always @(posedge clk) line <= {line[3:0], chal_in};

  always_comb begin
    chal_out = chal_in;
    case (mode)
      1: chal_out = line[4];
      2: chal_out = 1'b0;
      3: chal_out = 1'b1;
      default: chal_out = chal_in;
    endcase
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic pol);
    @(negedge clk);
    polarity = pol;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, done, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_inv = 1'b0; polarity = 1'b0; mode = 0;
    done_cnt = 0; busy_cnt = 0;
    #22;
    check("rst_chal_in", chal_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_delay", delay, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: wire cell, rising edge
    mode = 0;
    @(negedge clk);
    done_cnt = 0; busy_cnt = 0;
    pulse_start(1'b0);
    wait_done("t1", 50);
    check("t1_delay", delay, 2);
    check("t1_timeout", timeout, 0);
    check("t1_chal_in", chal_in, 1);
    check("t1_busy_cycles", busy_cnt, 4);
    @(negedge clk);
    check("t1_done_one_cycle", done, 0);
    repeat (10) @(negedge clk);
    check("t1_done_count", done_cnt, 1);

    // 2: five-cycle cell delay, falling edge
    mode = 1;
    repeat (8) @(negedge clk);
    pulse_start(1'b1);
    wait_done("t2", 100);
    check("t2_delay", delay, 7);
    check("t2_chal_in", chal_in, 0);
    check("t2_timeout", timeout, 0);

    // 3: stuck 0 -> measure phase times out
    mode = 2;
    repeat (4) @(negedge clk);
    pulse_start(1'b0);
    wait_done("t3", 1100);
    check("t3_timeout", timeout, 1);
    check("t3_delay", delay, 1000);
    check("t3_chal_in", chal_in, 1);

    // 4: stuck 1 -> preset phase times out
    mode = 3;
    repeat (4) @(negedge clk);
    pulse_start(1'b0);
    check("t4_timeout_cleared", timeout, 0);
    wait_done("t4", 1100);
    check("t4_timeout", timeout, 1);
    check("t4_delay", delay, 0);
    check("t4_chal_in", chal_in, 0);

    // 5: start held high -> back-to-back measurements
    mode = 0;
    repeat (6) @(negedge clk);
    done_cnt = 0;
    polarity = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wait_done("t5", 50);
      check("t5_delay", delay, 2);
      check("t5_timeout", timeout, 0);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("t5_done_count", done_cnt, 3);

    // 5b: start pulses during busy are ignored
    done_cnt = 0;
    pulse_start(1'b0);
    pulse_start(1'b1);
    wait_done("t5b", 50);
    check("t5b_delay", delay, 2);
    repeat (20) @(negedge clk);
    check("t5b_done_count", done_cnt, 1);
    check("t5b_busy", busy, 0);

    // 6: reset mid-measure
    mode = 2;
    repeat (4) @(negedge clk);
    pulse_start(1'b0);
    repeat (10) @(negedge clk);
    check("t6_busy_before", busy, 1);
    check("t6_chal_in_before", chal_in, 1);
    done_cnt = 0;
    #2 rst = 1'b1;
    #1;
    check("t6_chal_in", chal_in, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_timeout", timeout, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_no_done", done_cnt, 0);

    // 6b: inverting cell
    @(negedge clk);
    start_inv = 1'b1;
    @(negedge clk);
    start_inv = 1'b0;
    for (int n = 0; n < 50 && !done_inv; n++) @(negedge clk);
    check("t6b_done_seen", done_inv, 1);
    check("t6b_delay", delay_inv, 2);
    check("t6b_timeout", timeout_inv, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
